// File: rtl/push_counter_pkg.sv
// Shared game definitions: speed-round state encoding and the default press-counter width.
package push_counter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ROUND = 1'b1
  } state_t;

  // Also used by the display logic to size its score fields.
  localparam int unsigned CNT_W_DEFAULT = 8;

endpackage

// File: rtl/rise_detect.sv
// Single-bit 0->1 edge detector; the history register tracks the input in every state.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (!rst) d_q <= 1'b0;
    else      d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/push_counter.sv
// Speed-round press tally: counts left/right button presses and reports tie / right-ahead.
module push_counter
  import push_counter_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic pbl,
  input  logic pbr,
  input  logic speedRound,
  input  logic speedExit,
  output logic speed_tie,
  output logic speed_right
);

  state_t           state, state_next;
  logic             press_l, press_r;
  logic [CNT_W-1:0] cnt_l, cnt_r;
  logic             start, counting;

  rise_detect u_rise_l (.clk(clk), .rst(rst), .d(pbl), .rise(press_l));
  rise_detect u_rise_r (.clk(clk), .rst(rst), .d(pbr), .rise(press_r));

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    counting   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (speedRound && !speedExit) begin
          state_next = ST_ROUND;
          start      = 1'b1;
        end
      end
      ST_ROUND: begin
        if (speedExit) state_next = ST_IDLE;
        else           counting   = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Saturating counters: a press at full scale is dropped rather than wrapping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_l <= '0;
      cnt_r <= '0;
    end else if (start) begin
      cnt_l <= '0;
      cnt_r <= '0;
    end else if (counting) begin
      if (press_l && cnt_l != '1) cnt_l <= cnt_l + CNT_W'(1);
      if (press_r && cnt_r != '1) cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Outputs also update on the exit cycle, freezing the result seen at that edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      speed_tie   <= 1'b0;
      speed_right <= 1'b0;
    end else if (state == ST_ROUND) begin
      speed_tie   <= (cnt_l == cnt_r);
      speed_right <= (cnt_r > cnt_l);
    end
  end

endmodule

// File: tb/tb_push_counter.sv
// Directed bench for push_counter: an 8-bit instance plus a 2-bit instance for saturation.
module tb_push_counter;

  logic clk = 1'b0;
  logic rst, pbl, pbr, speedRound, speedExit;
  logic tie8, right8, tie2, right2;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  push_counter #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .pbl(pbl), .pbr(pbr),
    .speedRound(speedRound), .speedExit(speedExit),
    .speed_tie(tie8), .speed_right(right8)
  );

  push_counter #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .pbl(pbl), .pbr(pbr),
    .speedRound(speedRound), .speedExit(speedExit),
    .speed_tie(tie2), .speed_right(right2)
  );

  task automatic step(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_l(input int unsigned hi, input int unsigned lo);
    pbl = 1'b1; step(hi); pbl = 1'b0; step(lo);
  endtask

  task automatic press_r(input int unsigned hi, input int unsigned lo);
    pbr = 1'b1; step(hi); pbr = 1'b0; step(lo);
  endtask

  task automatic test_reset();
    rst = 1'b0; pbl = 1'b0; pbr = 1'b0; speedRound = 1'b0; speedExit = 1'b0;
    step(1);
    rst = 1'b1;
    step(1);
    checks++; if ({tie8, right8} !== 2'b00) begin failures++; $display("FAIL reset_out8 got=%b want=00", {tie8, right8}); end
    checks++; if ({tie2, right2} !== 2'b00) begin failures++; $display("FAIL reset_out2 got=%b want=00", {tie2, right2}); end
    // Presses in IDLE must not move anything.
    press_r(1, 1);
    press_l(1, 3);
    checks++; if ({tie8, right8} !== 2'b00) begin failures++; $display("FAIL idle_press_out got=%b want=00", {tie8, right8}); end
    checks++; if (dut.cnt_l !== 8'd0) begin failures++; $display("FAIL idle_press_cnt_l got=%0d want=0", dut.cnt_l); end
  endtask

  task automatic test_round_start();
    speedRound = 1'b1;
    step(1);
    speedRound = 1'b0;
    checks++; if (tie8 !== 1'b0) begin failures++; $display("FAIL start_latency_early got=%b want=0", tie8); end
    step(1);
    checks++; if ({tie8, right8} !== 2'b10) begin failures++; $display("FAIL start_tie got=%b want=10", {tie8, right8}); end
  endtask

  task automatic test_presses();
    for (int i = 0; i < 3; i++) press_l(5, 5);
    for (int i = 0; i < 2; i++) press_r(5, 5);
    checks++; if ({tie8, right8} !== 2'b00) begin failures++; $display("FAIL left_ahead got=%b want=00", {tie8, right8}); end
    press_r(5, 5);
    checks++; if ({tie8, right8} !== 2'b10) begin failures++; $display("FAIL tie_3_3 got=%b want=10", {tie8, right8}); end
    pbr = 1'b1; step(1);
    checks++; if ({tie8, right8} !== 2'b10) begin failures++; $display("FAIL press_latency_early got=%b want=10", {tie8, right8}); end
    step(1);
    checks++; if ({tie8, right8} !== 2'b01) begin failures++; $display("FAIL right_ahead got=%b want=01", {tie8, right8}); end
    pbr = 1'b0; step(4);
    checks++; if (dut.cnt_r !== 8'd4) begin failures++; $display("FAIL cnt_r_four got=%0d want=4", dut.cnt_r); end
  endtask

  task automatic test_held_button();
    speedExit = 1'b1; step(1); speedExit = 1'b0; step(2);
    checks++; if ({tie8, right8} !== 2'b01) begin failures++; $display("FAIL exit_hold_result got=%b want=01", {tie8, right8}); end
    pbl = 1'b1; step(2);
    speedRound = 1'b1; step(1); speedRound = 1'b0; step(3);
    checks++; if (dut.cnt_l !== 8'd0) begin failures++; $display("FAIL held_not_counted got=%0d want=0", dut.cnt_l); end
    checks++; if ({tie8, right8} !== 2'b10) begin failures++; $display("FAIL held_tie got=%b want=10", {tie8, right8}); end
    pbl = 1'b0; step(2);
    press_l(1, 3);
    checks++; if (dut.cnt_l !== 8'd1) begin failures++; $display("FAIL repress_cnt_l got=%0d want=1", dut.cnt_l); end
    checks++; if ({tie8, right8} !== 2'b00) begin failures++; $display("FAIL repress_left_ahead got=%b want=00", {tie8, right8}); end
  endtask

  task automatic test_back_to_back();
    press_r(1, 3);
    checks++; if ({tie8, right8} !== 2'b10) begin failures++; $display("FAIL tie_1_1 got=%b want=10", {tie8, right8}); end
    pbl = 1'b1; pbr = 1'b1; step(1); pbl = 1'b0; pbr = 1'b0; step(3);
    checks++; if (dut.cnt_l !== 8'd2 || dut.cnt_r !== 8'd2) begin
      failures++; $display("FAIL simul_counts got=%0d/%0d want=2/2", dut.cnt_l, dut.cnt_r); end
    checks++; if ({tie8, right8} !== 2'b10) begin failures++; $display("FAIL simul_tie got=%b want=10", {tie8, right8}); end
    speedExit = 1'b1; pbr = 1'b1; step(1); speedExit = 1'b0; pbr = 1'b0; step(3);
    checks++; if (dut.cnt_r !== 8'd2) begin failures++; $display("FAIL exit_press_cnt_r got=%0d want=2", dut.cnt_r); end
    checks++; if ({tie8, right8} !== 2'b10) begin failures++; $display("FAIL exit_press_out got=%b want=10", {tie8, right8}); end
    press_r(1, 3);
    checks++; if ({tie8, right8} !== 2'b10) begin failures++; $display("FAIL idle_after_exit got=%b want=10", {tie8, right8}); end
  endtask

  task automatic test_saturation();
    speedRound = 1'b1; step(1); speedRound = 1'b0; step(2);
    checks++; if ({tie2, right2} !== 2'b10) begin failures++; $display("FAIL sat_start got=%b want=10", {tie2, right2}); end
    for (int i = 0; i < 5; i++) press_l(1, 1);
    for (int i = 0; i < 3; i++) press_r(1, 1);
    step(2);
    checks++; if ({tie2, right2} !== 2'b10) begin failures++; $display("FAIL sat_3_3 got=%b want=10", {tie2, right2}); end
    press_r(1, 3);
    checks++; if (dut2.cnt_l !== 2'd3 || dut2.cnt_r !== 2'd3) begin
      failures++; $display("FAIL sat_counts got=%0d/%0d want=3/3", dut2.cnt_l, dut2.cnt_r); end
    checks++; if ({tie2, right2} !== 2'b10) begin failures++; $display("FAIL sat_tie got=%b want=10", {tie2, right2}); end
    checks++; if ({tie8, right8} !== 2'b00) begin failures++; $display("FAIL wide_5_4 got=%b want=00", {tie8, right8}); end
  endtask

  task automatic test_mid_reset();
    rst = 1'b0; step(1); rst = 1'b1; step(1);
    checks++; if ({tie8, right8, tie2, right2} !== 4'b0000) begin
      failures++; $display("FAIL midreset_out got=%b want=0000", {tie8, right8, tie2, right2}); end
    press_l(1, 1);
    press_r(1, 1);
    press_r(1, 3);
    checks++; if ({tie8, right8} !== 2'b00) begin failures++; $display("FAIL midreset_ignored got=%b want=00", {tie8, right8}); end
    checks++; if (dut.cnt_r !== 8'd0) begin failures++; $display("FAIL midreset_cnt_r got=%0d want=0", dut.cnt_r); end
    speedRound = 1'b1; step(1); speedRound = 1'b0; step(1);
    checks++; if ({tie8, right8} !== 2'b10) begin failures++; $display("FAIL restart_tie got=%b want=10", {tie8, right8}); end
  endtask

  initial begin
    rst = 1'b0; pbl = 1'b0; pbr = 1'b0; speedRound = 1'b0; speedExit = 1'b0;
    step(1);
    test_reset();
    test_round_start();
    test_presses();
    test_held_button();
    test_back_to_back();
    test_saturation();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
